// File: rtl/finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq_if.sv
// Operand/result handshake bundle for the sequential 32s / 30ns divider.
// The slave modport is the divider side; the master modport is the producer/consumer side.
interface finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq_if #(
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 30,
   parameter int DOUT_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DIN0_WIDTH-1:0] din0;
   logic [DIN1_WIDTH-1:0] din1;
   logic                  out_valid;
   logic                  out_ready;
   logic [DOUT_WIDTH-1:0] quot;
   logic [DOUT_WIDTH-1:0] rem;
   logic                  div_by_zero;

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, quot, rem, div_by_zero
   );

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, quot, rem, div_by_zero
   );
endinterface

// File: rtl/finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq.sv
// Radix-2 restoring divider, signed 32-bit dividend by unsigned 30-bit divisor, one quotient bit per clock.
// Result valid 34 edges after acceptance (counting the accepting edge), 1 edge for divide-by-zero; holds result under backpressure.
module finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq #(
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 30,
   parameter int DOUT_WIDTH = 32
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq_if.slave bus
);
   localparam int CW = $clog2(DIN0_WIDTH);
   localparam int PW = DIN1_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  accept;
   logic                  div_zero_in;
   logic                  in_ready;
   logic                  out_valid;

   logic [CW-1:0]         cnt;
   logic [DIN0_WIDTH-1:0] dvd;
   logic [DIN0_WIDTH-1:0] q;
   logic [DIN1_WIDTH-1:0] dvs;
   logic [PW-1:0]         r;
   logic                  neg;

   logic [PW-1:0]         trial;
   logic [PW:0]           diff;
   logic                  take;
   logic [PW-1:0]         r_nxt;
   logic [DIN0_WIDTH-1:0] din0_mag;
   logic [DOUT_WIDTH-1:0] rem_mag;

   logic [DOUT_WIDTH-1:0] quot_r;
   logic [DOUT_WIDTH-1:0] rem_r;
   logic                  dbz_r;

   assign accept      = bus.in_valid && in_ready;
   assign div_zero_in = (bus.din1 == '0);
   // -2^31 negates to itself, which is exactly the 0x80000000 magnitude wanted
   assign din0_mag    = bus.din0[DIN0_WIDTH-1] ? (~bus.din0 + 1'b1) : bus.din0;

   // The remainder stays below the divisor, so its top bit is always free for the shifted-in dividend bit
   assign trial = {r[PW-2:0], dvd[DIN0_WIDTH-1]};
   assign diff  = {1'b0, trial} - {2'b00, dvs};
   assign take  = ~diff[PW];
   assign r_nxt = take ? diff[PW-1:0] : trial;

   assign rem_mag = {{(DOUT_WIDTH-PW){1'b0}}, r};

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = div_zero_in ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt    <= '0;
         dvd    <= '0;
         q      <= '0;
         dvs    <= '0;
         r      <= '0;
         neg    <= 1'b0;
         quot_r <= '0;
         rem_r  <= '0;
         dbz_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt <= CW'(DIN0_WIDTH - 1);
                  dvd <= din0_mag;
                  q   <= '0;
                  dvs <= bus.din1;
                  r   <= '0;
                  neg <= bus.din0[DIN0_WIDTH-1];
                  if (div_zero_in) begin
                     quot_r <= '0;
                     rem_r  <= DOUT_WIDTH'($signed(bus.din0));
                     dbz_r  <= 1'b1;
                  end
               end
            end
            CALC: begin
               r   <= r_nxt;
               q   <= {q[DIN0_WIDTH-2:0], take};
               dvd <= {dvd[DIN0_WIDTH-2:0], 1'b0};
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               quot_r <= neg ? (~DOUT_WIDTH'(q) + 1'b1) : DOUT_WIDTH'(q);
               rem_r  <= neg ? (~rem_mag + 1'b1) : rem_mag;
               dbz_r  <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.quot        = quot_r;
   assign bus.rem         = rem_r;
   assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq.sv
// Bench for the sequential divider: directed corner cases, backpressure, mid-operation reset and random operands vs a C-division model.
module tb_finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq;
   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq_if #(
      .DIN0_WIDTH(32), .DIN1_WIDTH(30), .DOUT_WIDTH(32)
   ) bus ();

   finn_feeder_chiplet_8_bits_sdiv_32s_30ns_32_seq #(
      .DIN0_WIDTH(32), .DIN1_WIDTH(30), .DOUT_WIDTH(32)
   ) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .bus     (bus)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Truncating division in 64-bit arithmetic
   function automatic void ref_div(input logic [31:0] a, input logic [29:0] b,
                                   output logic [31:0] eq, output logic [31:0] er,
                                   output logic ez);
      longint la;
      longint lb;
      if (b == 30'd0) begin
         eq = 32'd0;
         er = a;
         ez = 1'b1;
      end else begin
         la = longint'($signed(a));
         lb = longint'({34'd0, b});
         eq = 32'(la / lb);
         er = 32'(la % lb);
         ez = 1'b0;
      end
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [29:0] b, input int pre_gap,
                         input int hold, input bit noise, input string tag);
      logic [31:0] eq, er;
      logic        ez;
      int          n;
      int          lat;
      ref_div(a, b, eq, er, ez);
      repeat (pre_gap) @(negedge ap_clk);
      bus.in_valid = 1'b1;
      bus.din0     = a;
      bus.din1     = b;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge ap_clk);
         n++;
      end
      if (!bus.in_ready) begin
         chk({tag, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
      lat = 1;
      bus.in_valid = noise ? 1'($urandom) : 1'b0;
      bus.din0     = $urandom;
      bus.din1     = 30'($urandom);
      while (!bus.out_valid && lat < 100) begin
         @(negedge ap_clk);
         lat++;
         if (noise) begin
            bus.in_valid = 1'($urandom);
            bus.din0     = $urandom;
            bus.din1     = 30'($urandom);
         end
      end
      bus.in_valid = 1'b0;
      chk({tag, "_lat"}, 32'(lat), (b == 30'd0) ? 32'd1 : 32'd34);
      if (!bus.out_valid) return;
      chk({tag, "_quot"}, bus.quot, eq);
      chk({tag, "_rem"},  bus.rem,  er);
      chk({tag, "_dbz"},  32'(bus.div_by_zero), 32'(ez));
      for (int i = 0; i < hold; i++) begin
         @(negedge ap_clk);
         chk({tag, "_hold_vld"},  32'(bus.out_valid), 32'd1);
         chk({tag, "_hold_rdy"},  32'(bus.in_ready), 32'd0);
         chk({tag, "_hold_quot"}, bus.quot, eq);
         chk({tag, "_hold_rem"},  bus.rem, er);
         chk({tag, "_hold_dbz"},  32'(bus.div_by_zero), 32'(ez));
      end
      bus.out_ready = 1'b1;
      @(negedge ap_clk);
      bus.out_ready = 1'b0;
      chk({tag, "_post_vld"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_post_rdy"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      int          vcount;
      logic [31:0] a;
      logic [29:0] b;
      int          sel;

      bus.in_valid  = 1'b0;
      bus.din0      = '0;
      bus.din1      = '0;
      bus.out_ready = 1'b0;

      #12;
      chk("rst_vld",  32'(bus.out_valid), 32'd0);
      chk("rst_quot", bus.quot, 32'd0);
      chk("rst_rem",  bus.rem, 32'd0);
      chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      chk("rst_rdy", 32'(bus.in_ready), 32'd1);

      run_op(32'd100, 30'd7, 0, 0, 1'b0, "t1");
      run_op(-32'sd100, 30'd7, 1, 0, 1'b0, "t2a");
      run_op(-32'sd5, 30'd10, 0, 0, 1'b0, "t2b");
      run_op(32'h8000_0000, 30'd1, 0, 0, 1'b0, "t3a");
      run_op(32'h7FFF_FFFF, 30'h3FFF_FFFF, 0, 0, 1'b0, "t3b");
      run_op(32'h8000_0000, 30'h3FFF_FFFF, 0, 0, 1'b0, "t3c");
      run_op(32'd0, 30'd5, 0, 0, 1'b0, "t3d");
      run_op(-32'sd7, 30'd7, 0, 0, 1'b0, "t3e");
      run_op(32'd1234, 30'd0, 0, 0, 1'b0, "t4");
      run_op(32'hFFFF_FF00, 30'd0, 0, 0, 1'b0, "t4n");
      run_op(32'd1234, 30'd0, 0, 0, 1'b0, "t4b");
      run_op(32'd999, 30'd13, 0, 5, 1'b1, "t5");

      // Leave a nonzero result in the output registers so the reset clear is observable
      run_op(-32'sd1234, 30'd0, 0, 0, 1'b0, "t6pre");
      @(negedge ap_clk);
      bus.in_valid = 1'b1;
      bus.din0     = 32'd100;
      bus.din1     = 30'd7;
      @(posedge ap_clk);
      @(negedge ap_clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      chk("t6_quot", bus.quot, 32'd0);
      chk("t6_rem",  bus.rem, 32'd0);
      chk("t6_dbz",  32'(bus.div_by_zero), 32'd0);
      chk("t6_vld",  32'(bus.out_valid), 32'd0);
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge ap_clk);
         if (bus.out_valid) vcount++;
      end
      chk("t6_no_vld", 32'(vcount), 32'd0);
      run_op(32'd100, 30'd7, 0, 0, 1'b0, "t6post");

      for (int i = 0; i < 1200; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0:       b = 30'd0;
            1, 2, 3: b = 30'($urandom_range(1, 20));
            4:       b = 30'h3FFF_FFFF;
            default: b = 30'($urandom);
         endcase
         sel = $urandom_range(0, 9);
         case (sel)
            0:       a = 32'h8000_0000;
            1:       a = 32'h7FFF_FFFF;
            2:       a = 32'($urandom_range(0, 100)) - 32'd50;
            default: a = $urandom;
         endcase
         run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
